// File: rtl/mem_scrubber.sv
// Memory scrubber: walks every byte of NUM_BANKS x BANK_DEPTH RAM, compares it to a
// latched pattern, rewrites mismatching bytes and reports byte/bit error counts.
module mem_scrubber #(
  parameter int NUM_BANKS  = 20,
  parameter int BANK_DEPTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [7:0]           i_pattern,
  input  logic                 i_grant,
  output logic                 o_req,
  output logic [NUM_BANKS-1:0] o_cs,
  output logic [8:0]           o_addr,
  output logic                 o_rw,
  output logic [7:0]           o_data_byte,
  input  logic [7:0]           i_data_byte,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_byte_err,
  output logic [15:0]          o_bit_err
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [8:0]        LAST_ADDR = 9'(BANK_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [8:0]        addr_q, addr_d;
  logic [7:0]        pattern_q, pattern_d;
  logic [15:0]       byte_err_q, byte_err_d;
  logic [15:0]       bit_err_q, bit_err_d;
  logic [7:0]        diff;
  logic [NUM_BANKS-1:0] cs_onehot;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    pattern_d   = pattern_q;
    byte_err_d  = byte_err_q;
    bit_err_d   = bit_err_q;
    diff        = i_data_byte ^ pattern_q;
    cs_onehot   = '0;
    cs_onehot[bank_q] = 1'b1;

    o_req       = (state_q != S_IDLE) && (state_q != S_DONE);
    o_busy      = (state_q != S_IDLE);
    o_done      = (state_q == S_DONE);
    o_rw        = (state_q == S_WRITE);
    o_cs        = ((state_q == S_READ) || (state_q == S_WRITE)) ? cs_onehot : '0;
    o_addr      = addr_q;
    o_data_byte = (state_q != S_IDLE) ? pattern_q : 8'h00;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pattern_d  = i_pattern;
          byte_err_d = '0;
          bit_err_d  = '0;
          bank_d     = '0;
          addr_d     = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ:   if (i_grant) state_d = S_READ;
      S_READ:  state_d = S_WAIT;
      // Read data returns during WAIT; a mismatch is counted here and repaired in WRITE.
      S_WAIT: begin
        if (diff != 8'h00) begin
          byte_err_d = sat_add16(byte_err_q, 4'd1);
          bit_err_d  = sat_add16(bit_err_q, popcount8(diff));
          state_d    = S_WRITE;
        end else begin
          state_d    = S_NEXT;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if ((addr_q == LAST_ADDR) && (bank_q == LAST_BANK)) begin
          state_d = S_DONE;
        end else begin
          if (addr_q == LAST_ADDR) begin
            addr_d = 9'd0;
            bank_d = bank_q + 1'b1;
          end else begin
            addr_d = addr_q + 9'd1;
          end
          state_d = i_grant ? S_READ : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      byte_err_q <= '0;
      bit_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      byte_err_q <= byte_err_d;
      bit_err_q  <= bit_err_d;
    end
  end

  // Pattern is only observed while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    pattern_q <= pattern_d;
  end

  assign o_byte_err = byte_err_q;
  assign o_bit_err  = bit_err_q;

endmodule

// File: tb/tb_mem_scrubber.sv
// Bench for mem_scrubber: RAM model, write scoreboard, read-order model, and a
// 20-bank instance running a saturating all-mismatch scan in the background.
`timescale 1ns/1ps
module tb_mem_scrubber;
  localparam int NB     = 4;
  localparam int BD     = 512;
  localparam int NBYTES = NB * BD;
  localparam int NBS    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, grant, grant_base, toggle_en, tgl_grant;
  logic [7:0]    pattern, rdata;
  logic          req, rw, busy, done;
  logic [NB-1:0] cs;
  logic [8:0]    addr;
  logic [7:0]    wdata;
  logic [15:0]   byte_err, bit_err;

  logic           rst_s, start_s, grant_s, req_s, rw_s, busy_s, done_s;
  logic [7:0]     pattern_s, rdata_s, wdata_s;
  logic [NBS-1:0] cs_s;
  logic [8:0]     addr_s;
  logic [15:0]    byte_err_s, bit_err_s;

  assign grant_s = 1'b1;
  assign rdata_s = 8'h00;

  mem_scrubber #(.NUM_BANKS(NB), .BANK_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_pattern(pattern), .i_grant(grant),
    .o_req(req), .o_cs(cs), .o_addr(addr), .o_rw(rw), .o_data_byte(wdata),
    .i_data_byte(rdata), .o_busy(busy), .o_done(done),
    .o_byte_err(byte_err), .o_bit_err(bit_err));

  mem_scrubber #(.NUM_BANKS(NBS), .BANK_DEPTH(BD)) dut_sat (
    .clk(clk), .reset(rst_s), .i_start(start_s), .i_pattern(pattern_s), .i_grant(grant_s),
    .o_req(req_s), .o_cs(cs_s), .o_addr(addr_s), .o_rw(rw_s), .o_data_byte(wdata_s),
    .i_data_byte(rdata_s), .o_busy(busy_s), .o_done(done_s),
    .o_byte_err(byte_err_s), .o_bit_err(bit_err_s));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int cs_bank(input logic [NB-1:0] c);
    for (int i = 0; i < NB; i++) if (c[i]) return i;
    return -1;
  endfunction

  // RAM model with a backdoor for filling and planting errors while the DUT is idle
  logic [7:0] mem [NBYTES];
  logic       bd_fill, bd_en;
  logic [7:0] bd_val;
  int         bd_idx;
  int         acc_idx;
  assign acc_idx = cs_bank(cs) * BD + int'(addr);

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < NBYTES; i++) mem[i] <= bd_val;
    end else if (bd_en) begin
      mem[bd_idx] <= bd_val;
    end else if (cs != '0 && acc_idx >= 0 && acc_idx < NBYTES) begin
      if (rw) mem[acc_idx] <= wdata;
      else    rdata <= mem[acc_idx];
    end
  end

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;
  assign tgl_grant = (tcyc % 200) >= 50;
  assign grant = toggle_en ? tgl_grant : grant_base;

  typedef struct {
    int         loc;
    logic [7:0] data;
  } wr_t;
  wr_t exp_wr[$];
  wr_t mon_e;

  int rd_cnt = 0, wr_cnt = 0, exp_rd_loc = 0, low_run = 0;
  int grant_viol = 0, done_cnt = 0, unexp_wr = 0;

  always @(negedge clk) begin
    if (grant) low_run = 0;
    else       low_run = low_run + 1;
    if (done) done_cnt++;
    if (cs != '0) begin
      if (low_run > 3) grant_viol++;
      if (rw) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          unexp_wr++;
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_loc", acc_idx, mon_e.loc);
          check("wr_data", 32'(wdata), 32'(mon_e.data));
        end
      end else begin
        rd_cnt++;
        check("rd_loc", acc_idx, exp_rd_loc);
        exp_rd_loc++;
      end
    end
  end

  int  wr_cnt_s = 0, rd_cnt_s = 0;
  bit  sat_done_seen = 1'b0;
  always @(negedge clk) begin
    if (cs_s != '0) begin
      if (rw_s) wr_cnt_s++;
      else      rd_cnt_s++;
    end
    if (done_s) sat_done_seen = 1'b1;
  end

  task automatic push_wr(input int loc, input logic [7:0] d);
    wr_t w;
    w.loc  = loc;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic fill(input logic [7:0] v);
    bd_val = v; bd_fill = 1'b1;
    @(posedge clk); #1 bd_fill = 1'b0;
  endtask

  task automatic plant(input int idx, input logic [7:0] v);
    bd_idx = idx; bd_val = v; bd_en = 1'b1;
    @(posedge clk); #1 bd_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] p);
    @(posedge clk); #1 start = 1'b1; pattern = p;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    32'(cs),       32'd0);
    check({tag, "_req"},   32'(req),      32'd0);
    check({tag, "_rw"},    32'(rw),       32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_done"},  32'(done),     32'd0);
    check({tag, "_addr"},  32'(addr),     32'd0);
    check({tag, "_wdata"}, 32'(wdata),    32'd0);
    check({tag, "_byte"},  32'(byte_err), 32'd0);
    check({tag, "_bit"},   32'(bit_err),  32'd0);
  endtask

  int cyc, n, acc0, rd0, wr0, d0;

  initial begin
    reset = 1'b1; rst_s = 1'b1; start = 1'b0; pattern = 8'h00;
    grant_base = 1'b1; toggle_en = 1'b0;
    bd_fill = 1'b0; bd_en = 1'b0; bd_val = 8'h00; bd_idx = 0;
    start_s = 1'b0; pattern_s = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    start_s = 1'b1; pattern_s = 8'hFF;
    @(posedge clk); #1 start_s = 1'b0;

    // Start with grant withheld: must sit in REQ without touching memory
    fill(8'hA5);
    grant_base = 1'b0;
    acc0 = rd_cnt + wr_cnt;
    exp_rd_loc = 0;
    pulse_start(8'hA5);
    repeat (20) @(posedge clk);
    #1;
    check("hold_req", 32'(req), 32'd1);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_noacc", rd_cnt + wr_cnt, acc0);

    // Clean scan: timing from grant is identical to a scan started with grant high
    grant_base = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
    wait_done("clean", 8000, cyc);
    check("clean_cycles", 32'((cyc >= 3 * NBYTES + 1) && (cyc <= 3 * NBYTES + 3)), 32'd1);
    check("clean_byte", 32'(byte_err), 32'd0);
    check("clean_bit", 32'(bit_err), 32'd0);
    check("clean_reads", rd_cnt - rd0, NBYTES);
    check("clean_writes", wr_cnt - wr0, 0);
    check("clean_done_cnt", done_cnt - d0, 1);

    // Two corrupt bytes (8 + 1 flipped bits), plus an ignored start mid-scan
    plant(1 * BD + 511, 8'h5A);
    plant(3 * BD, 8'hA4);
    push_wr(1 * BD + 511, 8'hA5);
    push_wr(3 * BD, 8'hA5);
    exp_rd_loc = 0; wr0 = wr_cnt;
    pulse_start(8'hA5);
    repeat (100) @(posedge clk);
    #1 start = 1'b1; pattern = 8'h00;
    @(posedge clk); #1 start = 1'b0;
    wait_done("err", 10000, cyc);
    check("err_byte", 32'(byte_err), 32'd2);
    check("err_bit", 32'(bit_err), 32'd9);
    check("err_writes", wr_cnt - wr0, 2);
    check("err_sb_empty", exp_wr.size(), 0);
    check("err_fixed_a", 32'(mem[1 * BD + 511]), 32'hA5);
    check("err_fixed_b", 32'(mem[3 * BD]), 32'hA5);

    // Same errors with grant periodically withdrawn
    plant(1 * BD + 511, 8'h5A);
    plant(3 * BD, 8'hA4);
    push_wr(1 * BD + 511, 8'hA5);
    push_wr(3 * BD, 8'hA5);
    exp_rd_loc = 0; wr0 = wr_cnt;
    toggle_en = 1'b1;
    pulse_start(8'hA5);
    wait_done("tgl", 14000, cyc);
    toggle_en = 1'b0;
    check("tgl_byte", 32'(byte_err), 32'd2);
    check("tgl_bit", 32'(bit_err), 32'd9);
    check("tgl_writes", wr_cnt - wr0, 2);
    check("tgl_sb_empty", exp_wr.size(), 0);
    check("tgl_grant_viol", grant_viol, 0);

    // Reset while in WAIT for a byte of bank 2
    plant(1 * BD + 511, 8'h5A);
    plant(3 * BD, 8'hA4);
    push_wr(1 * BD + 511, 8'hA5);
    exp_rd_loc = 0;
    pulse_start(8'hA5);
    n = 0;
    while (!(cs[2] === 1'b1 && rw === 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bank2", 32'(cs[2] === 1'b1 && rw === 1'b0), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_sb_empty", exp_wr.size(), 0);
    acc0 = rd_cnt + wr_cnt; d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_noacc", rd_cnt + wr_cnt, acc0);
    check("midrst_nodone", done_cnt, d0);
    check("midrst_idle", 32'(busy), 32'd0);

    plant(1 * BD + 511, 8'h5A);
    push_wr(1 * BD + 511, 8'hA5);
    push_wr(3 * BD, 8'hA5);
    exp_rd_loc = 0; wr0 = wr_cnt;
    pulse_start(8'hA5);
    check("restart_byte0", 32'(byte_err), 32'd0);
    wait_done("restart", 8000, cyc);
    check("restart_byte", 32'(byte_err), 32'd2);
    check("restart_bit", 32'(bit_err), 32'd9);
    check("restart_writes", wr_cnt - wr0, 2);
    check("restart_sb_empty", exp_wr.size(), 0);
    check("unexpected_writes", unexp_wr, 0);

    // Background 20-bank scan: every byte wrong in all 8 bits
    n = 0;
    while (!sat_done_seen && n < 45000) begin
      @(negedge clk);
      n++;
    end
    check("sat_done", 32'(sat_done_seen), 32'd1);
    check("sat_byte", 32'(byte_err_s), 32'd10240);
    check("sat_bit", 32'(bit_err_s), 32'hFFFF);
    check("sat_writes", wr_cnt_s, 10240);
    check("sat_reads", rd_cnt_s, 10240);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_scrubber.md
MEM_SCRUBBER -- requirements
Module: mem_scrubber

Interface
REQ-001 Parameter NUM_BANKS, default 20, number of RAM banks scanned (one chip-select bit each).
REQ-002 Parameter BANK_DEPTH, default 512, bytes per bank; address width 9 bits.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port i_start  input  1  single-cycle pulse; begins one full scan when idle.
REQ-006 Port i_pattern  input  8  expected byte; sampled on accepted i_start.
REQ-007 Port i_grant  input  1  memory-port ownership from the SPI-side arbiter; 1 = scrubber may issue accesses.
REQ-008 Port o_req  output  1  memory-port request.
REQ-009 Port o_cs  output  NUM_BANKS  one-hot bank select, all-zero when no access.
REQ-010 Port o_addr  output  9  byte address within bank.
REQ-011 Port o_rw  output  1  1 = write, 0 = read.
REQ-012 Port o_data_byte  output  8  write data.
REQ-013 Port i_data_byte  input  8  read data, valid exactly one cycle after a read cycle.
REQ-014 Port o_busy  output  1  scan in progress.
REQ-015 Port o_done  output  1  one-cycle pulse at scan end.
REQ-016 Port o_byte_err  output  16  count of mismatching bytes, last scan.
REQ-017 Port o_bit_err  output  16  count of flipped bits, last scan.

Function
REQ-018 States: IDLE, REQ, READ, WAIT, WRITE, NEXT, DONE; encoding free.
REQ-019 IDLE: i_start=1 -> latch i_pattern, clear both counters, bank=0, addr=0, go REQ; i_start ignored in all other states.
REQ-020 REQ: o_req=1; go READ when i_grant=1, else hold.
REQ-021 READ: one cycle, o_cs one-hot at bank, o_addr=addr, o_rw=0; go WAIT unconditionally.
REQ-022 WAIT: compare i_data_byte to latched pattern; mismatch -> byte counter +1, bit counter += popcount(xor), go WRITE; match -> go NEXT.
REQ-023 WRITE: one cycle, o_cs/o_addr as READ, o_rw=1, o_data_byte=pattern; go NEXT.
REQ-024 Counters saturate at 16'hFFFF; bit counter addition saturates, never wraps.
REQ-025 NEXT: addr+1; at BANK_DEPTH-1 wrap addr to 0, bank+1; at last byte of bank NUM_BANKS-1 go DONE, else go REQ if i_grant=0 or READ if i_grant=1.
REQ-026 o_req=1 in REQ, READ, WAIT, WRITE, NEXT; 0 in IDLE, DONE.
REQ-027 Accesses (o_cs nonzero) occur only in READ and WRITE; i_grant falling during WAIT/WRITE does not abort the current byte (grant lost only takes effect at NEXT).
REQ-028 DONE: o_done=1 for one cycle, go IDLE; counters hold until next accepted i_start.
REQ-029 o_busy=1 in every state except IDLE.
REQ-030 Throughput with i_grant held 1: 3 cycles per matching byte, 4 per mismatching byte.
REQ-031 o_data_byte=pattern whenever busy; o_rw=0 outside WRITE.

Reset
REQ-032 reset=1 forces IDLE immediately, asynchronously; o_cs=0, o_rw=0, o_req=0, o_busy=0, o_done=0, o_addr=0, o_data_byte=0, counters=0, bank=0.
REQ-033 reset mid-scan abandons the scan without issuing a further access; no o_done pulse.

Verification
REQ-034 Model filled with 8'hA5, pattern 8'hA5, grant=1 -> 10240 reads, zero writes, counters 0/0, o_done at cycle 30721 after start +- FSM entry.
REQ-035 Bank 3 addr 0x1FF = 8'h5A, bank 19 addr 0 = 8'hA4, rest 8'hA5 -> o_byte_err=2, o_bit_err=9, exactly two writes of 8'hA5 at those locations.
REQ-036 Grant toggled low for 50 cycles every 200 -> no o_cs activity while in REQ with grant=0, final counters identical to uninterrupted run.
REQ-037 Model all 8'h00, pattern 8'hFF, NUM_BANKS=20 -> o_byte_err=10240, o_bit_err saturates at 16'hFFFF.
REQ-038 reset asserted in WAIT of bank 5 -> outputs reach reset values same cycle; subsequent i_start restarts from bank 0 addr 0 with cleared counters.
REQ-039 i_start pulsed while busy -> ignored; pattern and counters unchanged.
